// File: rtl/mul_issue_ctrl.sv
// Requester-side controller for an M-extension multiplier: accepts MUL/MULH/MULHSU/MULHU ops,
// drives the start/busy/valid multiplier interface and returns the selected word on a response port.
module mul_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 64,
    parameter int REUSE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [XLEN-1:0]   mul_rs1,
    output logic [XLEN-1:0]   mul_rs2,
    output logic              mul_rs1_signed,
    output logic              mul_rs2_signed,
    output logic              mul_start,
    input  logic              mul_busy,
    input  logic              mul_valid,
    input  logic [2*XLEN-1:0] mul_result,
    output logic [2:0]        dbg_state
);
    // Handshakes: a request transfers on a rising edge with req_valid & req_ready, a response
    // transfers on a rising edge with rsp_valid & rsp_ready; valid never drops before its transfer
    // except when flush kills the op.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;
    localparam int CW = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                from_to_q, from_to_d;
    logic                is_mul_q, is_mul_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
    logic [4:0]          rsp_rd_q, rsp_rd_d;
    logic                rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]     mul_rs1_q, mul_rs1_d, mul_rs2_q, mul_rs2_d;
    logic                mul_s1_q, mul_s1_d, mul_s2_q, mul_s2_d;
    logic                c_vld_q, c_vld_d;
    logic [XLEN-1:0]     c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
    logic                c_s1_q, c_s1_d, c_s2_q, c_s2_d;
    logic [2*XLEN-1:0]   c_prod_q, c_prod_d;

    logic accept, req_s1, req_s2, req_is_mul, hit;

    function automatic logic [XLEN-1:0] sel_word(input logic [2*XLEN-1:0] p, input logic lo);
        return lo ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign req_ready  = (state_q == S_IDLE) & ~flush;
    assign accept     = req_valid & req_ready;
    assign req_s1     = (req_funct3 != 2'b11);
    assign req_s2     = ~req_funct3[1];
    assign req_is_mul = (req_funct3 == 2'b00);
    // The low product word is identical for signed and unsigned operands, so MUL ignores the flags.
    assign hit = (REUSE_EN != 0) & c_vld_q & (req_rs1 == c_rs1_q) & (req_rs2 == c_rs2_q)
               & (req_is_mul | ((req_s1 == c_s1_q) & (req_s2 == c_s2_q)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        from_to_d   = from_to_q;
        is_mul_d    = is_mul_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        mul_rs1_d   = mul_rs1_q;
        mul_rs2_d   = mul_rs2_q;
        mul_s1_d    = mul_s1_q;
        mul_s2_d    = mul_s2_q;
        c_vld_d     = c_vld_q;
        c_rs1_d     = c_rs1_q;
        c_rs2_d     = c_rs2_q;
        c_s1_d      = c_s1_q;
        c_s2_d      = c_s2_q;
        c_prod_d    = c_prod_q;
        mul_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rsp_rd_d  = req_rd;
                    is_mul_d  = req_is_mul;
                    rsp_err_d = 1'b0;
                    if (hit) begin
                        rsp_data_d  = sel_word(c_prod_q, req_is_mul);
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        mul_rs1_d = req_rs1;
                        mul_rs2_d = req_rs2;
                        mul_s1_d  = req_s1;
                        mul_s2_d  = req_s2;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!mul_busy) begin
                    mul_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt_q == 0 marks the first WAIT cycle, where a leftover mul_valid is not trusted.
                if (flush) begin
                    from_to_d = 1'b0;
                    state_d   = S_DRAIN;
                end else if ((cnt_q != '0) && mul_valid) begin
                    rsp_data_d  = sel_word(mul_result, is_mul_q);
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (REUSE_EN != 0) begin
                        c_vld_d  = 1'b1;
                        c_rs1_d  = mul_rs1_q;
                        c_rs2_d  = mul_rs2_q;
                        c_s1_d   = mul_s1_q;
                        c_s2_d   = mul_s2_q;
                        c_prod_d = mul_result;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    c_vld_d    = 1'b0;
                    from_to_d  = 1'b1;
                    state_d    = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (flush) from_to_d = 1'b0;
                if (mul_valid || !mul_busy) begin
                    if (from_to_q && !flush) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            from_to_q   <= 1'b0;
            is_mul_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            mul_rs1_q   <= '0;
            mul_rs2_q   <= '0;
            mul_s1_q    <= 1'b0;
            mul_s2_q    <= 1'b0;
            c_vld_q     <= 1'b0;
            c_rs1_q     <= '0;
            c_rs2_q     <= '0;
            c_s1_q      <= 1'b0;
            c_s2_q      <= 1'b0;
            c_prod_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_to_q   <= from_to_d;
            is_mul_q    <= is_mul_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            mul_rs1_q   <= mul_rs1_d;
            mul_rs2_q   <= mul_rs2_d;
            mul_s1_q    <= mul_s1_d;
            mul_s2_q    <= mul_s2_d;
            c_vld_q     <= c_vld_d;
            c_rs1_q     <= c_rs1_d;
            c_rs2_q     <= c_rs2_d;
            c_s1_q      <= c_s1_d;
            c_s2_q      <= c_s2_d;
            c_prod_q    <= c_prod_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_rd         = rsp_rd_q;
    assign rsp_err        = rsp_err_q;
    assign mul_rs1        = mul_rs1_q;
    assign mul_rs2        = mul_rs2_q;
    assign mul_rs1_signed = mul_s1_q;
    assign mul_rs2_signed = mul_s2_q;
    assign dbg_state      = state_q;

endmodule
